mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 32, core and bus data/address width; only 32 is supported.
REQ-003 clk_i  in  1  rising-edge clock.
REQ-004 rst_n_i  in  1  asynchronous active-low reset.
REQ-005 MemReq_i  in  1  core load/store request, held until Done_o.
REQ-006 MemWrite_i  in  1  1=store, 0=load.
REQ-007 MemType_i  in  2  00 word, 01 byte, 10 half; 11 treated as word.
REQ-008 MemSign_i  in  1  load extension: 0 sign-extend, 1 zero-extend.
REQ-009 Addr_i  in  32  byte address; WData_i  in  32  store data, right-aligned.
REQ-010 Stall_o  out  1  core stall; RData_o  out  32  extended load data; Done_o  out  1  one-cycle completion pulse.
REQ-011 BusReq_o  out  1  bus request; BusWe_o  out  1  write enable; BusAddr_o  out  32  word-aligned address; BusBe_o  out  4  byte lanes; BusWData_o  out  32  lane-positioned data.
REQ-012 BusGnt_i  in  1  beat accepted this cycle; BusRValid_i  in  1  read data valid; BusRData_i  in  32  read word.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
REQ-014 IDLE with MemReq_i=1 SHALL latch all request inputs and go to ISSUE0; inputs are not re-sampled until the next IDLE.
REQ-015 ISSUEx SHALL assert BusReq_o with BusAddr_o/BusBe_o/BusWData_o/BusWe_o stable until BusGnt_i=1.
REQ-016 On grant: store goes to ISSUE1 if split else DONE; load goes to WAITx.
REQ-017 WAITx SHALL capture BusRData_i on BusRValid_i=1, then go to ISSUE1 (if split and x=0) or DONE; BusRValid_i SHALL be ignored in all other states.
REQ-018 Split: access is split when offset+size>4 (half at offset 3; word at offset 1-3); beat0 = Addr&~3, lanes offset..3; beat1 = beat0+4 mod 2^32, remaining low lanes.
REQ-019 Byte lane mask SHALL be contiguous lanes starting at Addr_i[1:0] clipped per beat; BusWData_o SHALL carry the corresponding store bytes in those lanes, other lanes 0.
REQ-020 Load data SHALL be reassembled from beat0 upper bytes and beat1 lower bytes, then sign- or zero-extended from bit 7/15 per MemSign_i.
REQ-021 DONE SHALL pulse Done_o for one cycle, drive RData_o valid (0 for stores), return to IDLE; RData_o holds until the next load completes.
REQ-022 Stall_o SHALL equal MemReq_i AND NOT Done_o.
REQ-023 Latency with zero-wait bus: aligned store Done at T+2, aligned load T+3, split load T+5 (T = accept cycle).
REQ-024 At most one bus beat SHALL be outstanding.

Reset
REQ-025 Reset SHALL force IDLE and all outputs and latched registers to 0 asynchronously, including mid-transfer; a beat in flight is abandoned and its late BusRValid_i ignored.
REQ-026 First request after reset release SHALL be accepted in the first IDLE cycle with MemReq_i=1.

Structure
REQ-027 Package mem_pkg SHALL hold the FSM state enum and MemType encodings MT_WORD/MT_BYTE/MT_HALF.
REQ-028 Combinational lane shift/mask/extract/extend logic SHALL be a sub-module mem_lane_align; FSM and registers live in mem_access_ctrl.

Verification
REQ-029 Aligned lw Addr 0x100, gnt immediate, rdata 0xDEADBEEF next cycle -> BusAddr 0x100, Be 1111, RData_o 0xDEADBEEF, Done at T+3.
REQ-030 lb Addr 0x103 sign, rdata 0x80xxxxxx -> Be 1000, RData_o 0xFFFFFF80; lbu same -> 0x00000080.
REQ-031 sh Addr 0x202 WData 0x1234ABCD -> BusAddr 0x200, Be 1100, BusWData 0xABCD0000.
REQ-032 lw Addr 0x1FD, beat0 rdata 0x44332211, beat1 0x88776655 -> beats 0x1FC Be 1110, 0x200 Be 0001, RData_o 0x55443322.
REQ-033 sw Addr 0xFFFFFFFE -> beat1 BusAddr 0x00000000 Be 0011 (wrap).
REQ-034 Reset asserted in WAIT0 with BusGnt_i held low 3 cycles then rvalid after release -> BusReq_o 0 immediately, no Done_o, state IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state and memory access type encodings
package mem_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE} state_e;
  localparam logic [1:0] MT_WORD = 2'b00;
  localparam logic [1:0] MT_BYTE = 2'b01;
  localparam logic [1:0] MT_HALF = 2'b10;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane mask, store data positioning and load extract/extend
//   off_i/type_i/sign_i  access offset, size and load extension mode
//   wdata_i              right-aligned store data
//   rdata0_i/rdata1_i    read words of beat 0 and beat 1
//   split_o              access crosses a word boundary
//   be0_o/be1_o          byte lanes of beat 0 and beat 1
//   wdata0_o/wdata1_o    lane-positioned store data per beat
//   rdata_o              reassembled, extended load data
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  type_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata0_i,
  input  logic [31:0] rdata1_i,
  output logic        split_o,
  output logic [3:0]  be0_o,
  output logic [3:0]  be1_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] wdata1_o,
  output logic [31:0] rdata_o
);
  logic [3:0]  m;
  logic [7:0]  be_w;
  logic [31:0] wmask;
  logic [63:0] wd_w;
  logic [31:0] rd_w;
  assign m = type_i == MT_BYTE ? 4'b0001 : type_i == MT_HALF ? 4'b0011 : 4'b1111;
  assign wmask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  // Lanes above 3 after shifting belong to the second (next word) beat
  assign be_w = {4'b0000, m} << off_i;
  assign wd_w = {32'b0, wdata_i & wmask} << {off_i, 3'b000};
  assign rd_w = 32'({rdata1_i, rdata0_i} >> {off_i, 3'b000});
  assign split_o = |be_w[7:4];
  assign be0_o = be_w[3:0];
  assign be1_o = be_w[7:4];
  assign wdata0_o = wd_w[31:0];
  assign wdata1_o = wd_w[63:32];
  assign rdata_o = type_i == MT_BYTE ? {{24{~sign_i & rd_w[7]}}, rd_w[7:0]} :
                   type_i == MT_HALF ? {{16{~sign_i & rd_w[15]}}, rd_w[15:0]} : rd_w;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: core load/store to word bus bridge with misaligned split support
//   clk_i/rst_n_i         clock, asynchronous active-low reset
//   MemReq_i..WData_i     core request (held until Done_o), latched on accept
//   Stall_o/RData_o/Done_o core stall, extended load data, completion pulse
//   BusReq_o..BusWData_o  one-beat-at-a-time word bus request
//   BusGnt_i/BusRValid_i/BusRData_i  bus grant and read return
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  MemReq_i,
  input  logic                  MemWrite_i,
  input  logic [1:0]            MemType_i,
  input  logic                  MemSign_i,
  input  logic [DATA_WIDTH-1:0] Addr_i,
  input  logic [DATA_WIDTH-1:0] WData_i,
  output logic                  Stall_o,
  output logic [DATA_WIDTH-1:0] RData_o,
  output logic                  Done_o,
  output logic                  BusReq_o,
  output logic                  BusWe_o,
  output logic [DATA_WIDTH-1:0] BusAddr_o,
  output logic [3:0]            BusBe_o,
  output logic [DATA_WIDTH-1:0] BusWData_o,
  input  logic                  BusGnt_i,
  input  logic                  BusRValid_i,
  input  logic [DATA_WIDTH-1:0] BusRData_i
);
  state_e                state_q;
  logic                  we_q;
  logic                  sign_q;
  logic [1:0]            type_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rd0_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  split;
  logic                  issue;
  logic [3:0]            be0;
  logic [3:0]            be1;
  logic [31:0]           wd0;
  logic [31:0]           wd1;
  logic [31:0]           rd0;
  logic [31:0]           rext;
  // In WAIT0 the live bus word is beat 0, so the final value can be registered on the same edge
  assign rd0 = state_q == WAIT0 ? BusRData_i : rd0_q;
  mem_lane_align u_align (
    .off_i    (addr_q[1:0]),
    .type_i   (type_q),
    .sign_i   (sign_q),
    .wdata_i  (wdata_q),
    .rdata0_i (rd0),
    .rdata1_i (BusRData_i),
    .split_o  (split),
    .be0_o    (be0),
    .be1_o    (be1),
    .wdata0_o (wd0),
    .wdata1_o (wd1),
    .rdata_o  (rext)
  );
  assign issue      = state_q == ISSUE0 || state_q == ISSUE1;
  assign BusReq_o   = issue;
  assign BusWe_o    = issue & we_q;
  assign BusAddr_o  = issue ? {addr_q[31:2], 2'b00} + (state_q == ISSUE1 ? 32'd4 : 32'd0) : '0;
  assign BusBe_o    = state_q == ISSUE0 ? be0 : state_q == ISSUE1 ? be1 : 4'b0000;
  assign BusWData_o = !BusWe_o ? '0 : state_q == ISSUE1 ? wd1 : wd0;
  assign Done_o     = state_q == DONE;
  assign Stall_o    = MemReq_i & ~Done_o;
  assign RData_o    = rdata_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      type_q  <= MT_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (MemReq_i) begin
          state_q <= ISSUE0;
          we_q    <= MemWrite_i;
          sign_q  <= MemSign_i;
          type_q  <= MemType_i;
          addr_q  <= Addr_i;
          wdata_q <= WData_i;
        end
        ISSUE0: if (BusGnt_i) begin
          state_q <= !we_q ? WAIT0 : split ? ISSUE1 : DONE;
          if (we_q && !split) rdata_q <= '0;
        end
        WAIT0: if (BusRValid_i) begin
          rd0_q   <= BusRData_i;
          state_q <= split ? ISSUE1 : DONE;
          if (!split) rdata_q <= rext;
        end
        ISSUE1: if (BusGnt_i) begin
          state_q <= we_q ? DONE : WAIT1;
          if (we_q) rdata_q <= '0;
        end
        WAIT1: if (BusRValid_i) begin
          state_q <= DONE;
          rdata_q <= rext;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks against a byte-level reference model
module tb_mem_access_ctrl;
  logic        clk;
  logic        rst_n_i;
  logic        MemReq_i;
  logic        MemWrite_i;
  logic [1:0]  MemType_i;
  logic        MemSign_i;
  logic [31:0] Addr_i;
  logic [31:0] WData_i;
  logic        Stall_o;
  logic [31:0] RData_o;
  logic        Done_o;
  logic        BusReq_o;
  logic        BusWe_o;
  logic [31:0] BusAddr_o;
  logic [3:0]  BusBe_o;
  logic [31:0] BusWData_o;
  logic        BusGnt_i;
  logic        BusRValid_i;
  logic [31:0] BusRData_i;
  int          checks;
  int          errors;
  logic [31:0] last_rd;

  mem_access_ctrl #(.DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .MemReq_i    (MemReq_i),
    .MemWrite_i  (MemWrite_i),
    .MemType_i   (MemType_i),
    .MemSign_i   (MemSign_i),
    .Addr_i      (Addr_i),
    .WData_i     (WData_i),
    .Stall_o     (Stall_o),
    .RData_o     (RData_o),
    .Done_o      (Done_o),
    .BusReq_o    (BusReq_o),
    .BusWe_o     (BusWe_o),
    .BusAddr_o   (BusAddr_o),
    .BusBe_o     (BusBe_o),
    .BusWData_o  (BusWData_o),
    .BusGnt_i    (BusGnt_i),
    .BusRValid_i (BusRValid_i),
    .BusRData_i  (BusRData_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access with a bus responder; expectations come from a per-byte model
  task automatic access(input bit we, input logic [1:0] ty, input bit sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] r0, input logic [31:0] r1,
                        input int gdly, input int rdly, input string tag);
    int          sz, nb, b, bi, gw, rw, lat, ln;
    bit          rp, done;
    logic [31:0] ba [2];
    logic [3:0]  be [2];
    logic [31:0] bw [2];
    logic [31:0] base, ai, rb, v, rd;
    sz = ty == 2'b01 ? 1 : ty == 2'b10 ? 2 : 4;
    base = a & ~32'h3;
    ba[0] = base;
    ba[1] = base + 32'd4;
    be[0] = '0; be[1] = '0; bw[0] = '0; bw[1] = '0;
    nb = 1;
    v = '0;
    for (int i = 0; i < sz; i++) begin
      ai = a + 32'(i);
      bi = ((ai & ~32'h3) != base) ? 1 : 0;
      if (bi == 1) nb = 2;
      ln = int'(ai[1:0]);
      be[bi][ln] = 1'b1;
      bw[bi][8*ln +: 8] = wd[8*i +: 8];
      rb = bi == 1 ? r1 : r0;
      v[8*i +: 8] = rb[8*ln +: 8];
    end
    rd = we ? 32'h0 :
         sz == 1 ? ((!sg && v[7]) ? (v | 32'hFFFFFF00) : v) :
         sz == 2 ? ((!sg && v[15]) ? (v | 32'hFFFF0000) : v) : v;
    lat = 1 + nb * (gdly + 1) + (we ? 0 : nb * (rdly + 1));
    @(posedge clk); #1;
    MemReq_i = 1'b1; MemWrite_i = we; MemType_i = ty; MemSign_i = sg; Addr_i = a; WData_i = wd;
    b = 0; gw = gdly; rp = 0; done = 0; rw = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check({tag, "_idle_req"}, 32'(BusReq_o), 32'h0);
        check({tag, "_rdata_hold"}, RData_o, last_rd);
      end
      if (k == 1) begin
        MemWrite_i = ~we; MemType_i = 2'($urandom); MemSign_i = ~sg;
        Addr_i = $urandom; WData_i = $urandom;
      end
      BusGnt_i = 1'b0;
      BusRValid_i = 1'b0;
      BusRData_i = $urandom;
      if (Done_o) begin
        check({tag, "_latency"}, 32'(k), 32'(lat));
        check({tag, "_rdata"}, RData_o, rd);
        check({tag, "_beats"}, 32'(b), 32'(nb));
        check({tag, "_stall_done"}, 32'(Stall_o), 32'h0);
        done = 1;
        last_rd = rd;
      end else begin
        check({tag, "_stall"}, 32'(Stall_o), 32'h1);
        if (rp) begin
          check({tag, "_outstanding"}, 32'(BusReq_o), 32'h0);
          if (rw == 0) begin
            BusRValid_i = 1'b1;
            BusRData_i = b == 1 ? r0 : r1;
            rp = 0;
          end else rw--;
        end else if (BusReq_o) begin
          check({tag, "_beat_limit"}, 32'(b < nb), 32'h1);
          bi = b > 1 ? 1 : b;
          check({tag, "_addr"}, BusAddr_o, ba[bi]);
          check({tag, "_be"}, 32'(BusBe_o), 32'(be[bi]));
          check({tag, "_we"}, 32'(BusWe_o), 32'(we));
          if (we) check({tag, "_wdata"}, BusWData_o, bw[bi]);
          if (gw == 0) begin
            BusGnt_i = 1'b1;
            b++;
            gw = gdly;
            if (!we) begin rp = 1; rw = rdly; end
          end else begin
            gw--;
            BusRValid_i = 1'b1;
          end
        end
      end
    end
    check({tag, "_completed"}, 32'(done), 32'h1);
    MemReq_i = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; last_rd = '0;
    rst_n_i = 1'b0; MemReq_i = 1'b0; MemWrite_i = 1'b0; MemType_i = 2'b00; MemSign_i = 1'b0;
    Addr_i = '0; WData_i = '0; BusGnt_i = 1'b0; BusRValid_i = 1'b0; BusRData_i = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(BusReq_o), 32'h0);
    check("rst_done", 32'(Done_o), 32'h0);
    check("rst_rdata", RData_o, 32'h0);
    check("rst_addr", BusAddr_o, 32'h0);
    check("rst_be", 32'(BusBe_o), 32'h0);
    check("rst_stall", 32'(Stall_o), 32'h0);
    rst_n_i = 1'b1;

    access(0, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, "lw_aligned");
    access(0, 2'b01, 0, 32'h103, 32'h0, 32'h80123456, 32'h0, 0, 0, "lb_sign");
    check("lb_sign_value", RData_o, 32'hFFFFFF80);
    access(0, 2'b01, 1, 32'h103, 32'h0, 32'h80123456, 32'h0, 0, 0, "lbu_zero");
    check("lbu_value", RData_o, 32'h00000080);
    access(1, 2'b10, 0, 32'h202, 32'h1234ABCD, 32'h0, 32'h0, 0, 0, "sh_202");
    access(0, 2'b00, 0, 32'h1FD, 32'h0, 32'h44332211, 32'h88776655, 0, 0, "lw_split");
    check("lw_split_value", last_rd, 32'h55443322);
    access(1, 2'b00, 0, 32'hFFFFFFFE, 32'hA5A55A5A, 32'h0, 32'h0, 0, 0, "sw_wrap");
    access(0, 2'b10, 0, 32'h203, 32'h0, 32'hF0000000, 32'h000000C1, 1, 2, "lh_split");
    access(0, 2'b11, 1, 32'h41, 32'h0, 32'h11223344, 32'h55667788, 0, 1, "type11_word");
    access(1, 2'b00, 0, 32'h10, 32'hCAFEBABE, 32'h0, 32'h0, 0, 0, "sw_aligned");

    // Reset while waiting for read data; the late read return must be ignored
    access(0, 2'b00, 0, 32'h400, 32'h0, 32'h76543210, 32'h0, 0, 0, "lw_before_rst");
    @(posedge clk); #1;
    MemReq_i = 1'b1; MemWrite_i = 1'b0; MemType_i = 2'b00; Addr_i = 32'h1FD;
    @(negedge clk);
    @(negedge clk);
    check("rstA_issue_req", 32'(BusReq_o), 32'h1);
    BusGnt_i = 1'b1;
    @(negedge clk);
    BusGnt_i = 1'b0;
    check("rstA_wait_req", 32'(BusReq_o), 32'h0);
    #2 rst_n_i = 1'b0;
    #1;
    check("rstA_req", 32'(BusReq_o), 32'h0);
    check("rstA_done", 32'(Done_o), 32'h0);
    check("rstA_rdata", RData_o, 32'h0);
    MemReq_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    BusRValid_i = 1'b1;
    BusRData_i = 32'hCAFEF00D;
    @(negedge clk);
    BusRValid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstA_late_done", 32'(Done_o), 32'h0);
      check("rstA_late_req", 32'(BusReq_o), 32'h0);
      check("rstA_late_rdata", RData_o, 32'h0);
      @(negedge clk);
    end
    last_rd = '0;
    access(0, 2'b00, 0, 32'h100, 32'h0, 32'h0BADF00D, 32'h0, 0, 0, "first_after_rstA");

    // Reset while a store beat is being offered with no grant
    @(posedge clk); #1;
    MemReq_i = 1'b1; MemWrite_i = 1'b1; MemType_i = 2'b00; Addr_i = 32'h300; WData_i = 32'h13572468;
    @(negedge clk);
    @(negedge clk);
    check("rstB_issue_req", 32'(BusReq_o), 32'h1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rstB_req", 32'(BusReq_o), 32'h0);
    check("rstB_we", 32'(BusWe_o), 32'h0);
    check("rstB_wdata", BusWData_o, 32'h0);
    MemReq_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_i = 1'b1;
    last_rd = '0;
    access(1, 2'b01, 0, 32'h301, 32'h000000EE, 32'h0, 32'h0, 0, 0, "first_after_rstB");

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      access(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             ra, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
